// File: rtl/cache_pkg.sv
// Shared types and encodings for the 2-way set-associative write-back L1 cache controller.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_t;

  localparam int unsigned NUM_WAYS = 2;

  localparam logic PMEM_ADDR_CPU    = 1'b0;
  localparam logic PMEM_ADDR_VICTIM = 1'b1;

  localparam logic DATAIN_CPU  = 1'b0;
  localparam logic DATAIN_PMEM = 1'b1;

  function automatic logic [NUM_WAYS-1:0] way_onehot(input logic way);
    way_onehot      = '0;
    way_onehot[way] = 1'b1;
  endfunction

endpackage

// File: rtl/cache_control.sv
// Sequencing FSM for the 2-way write-back L1: hit service, victim write-back and line allocate.
module cache_control
  import cache_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic mem_read,
  input  logic mem_write,
  output logic mem_resp,
  input  logic hit0,
  input  logic hit1,
  input  logic dirty0,
  input  logic dirty1,
  input  logic lru,
  input  logic pmem_resp,
  output logic pmem_read,
  output logic pmem_write,
  output logic pmem_addr_sel,
  output logic way_sel,
  output logic datain_sel,
  output logic load_data0,
  output logic load_data1,
  output logic load_tag0,
  output logic load_tag1,
  output logic set_valid0,
  output logic set_valid1,
  output logic set_dirty0,
  output logic set_dirty1,
  output logic clr_dirty0,
  output logic clr_dirty1,
  output logic load_lru,
  output logic lru_in
);

  state_t state_q, state_d;

  logic req_s, hit_s, hway_s, victim_dirty_s;
  logic mem_resp_s, pmem_read_s, pmem_write_s, pmem_addr_sel_s;
  logic way_sel_s, datain_sel_s, load_lru_s, lru_in_s;
  logic [NUM_WAYS-1:0] load_data_s, load_tag_s, set_valid_s, set_dirty_s, clr_dirty_s;

  assign req_s          = mem_read | mem_write;
  assign hit_s          = hit0 | hit1;
  // Both ways hitting cannot happen legally; way 0 takes priority.
  assign hway_s         = hit1 & ~hit0;
  assign victim_dirty_s = lru ? dirty1 : dirty0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_s && !hit_s) begin
          state_d = victim_dirty_s ? WRITEBACK : ALLOCATE;
        end else begin
          state_d = IDLE;
        end
      end
      WRITEBACK: begin
        if (pmem_resp) begin
          state_d = ALLOCATE;
        end else begin
          state_d = WRITEBACK;
        end
      end
      // A started fill always completes, even if the CPU has dropped its request.
      ALLOCATE: begin
        if (pmem_resp) begin
          state_d = IDLE;
        end else begin
          state_d = ALLOCATE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_resp_s      = 1'b0;
    pmem_read_s     = 1'b0;
    pmem_write_s    = 1'b0;
    pmem_addr_sel_s = PMEM_ADDR_CPU;
    way_sel_s       = 1'b0;
    datain_sel_s    = DATAIN_CPU;
    load_lru_s      = 1'b0;
    lru_in_s        = 1'b0;
    load_data_s     = '0;
    load_tag_s      = '0;
    set_valid_s     = '0;
    set_dirty_s     = '0;
    clr_dirty_s     = '0;
    case (state_q)
      IDLE: begin
        if (req_s && hit_s) begin
          mem_resp_s = 1'b1;
          load_lru_s = 1'b1;
          lru_in_s   = ~hway_s;
          way_sel_s  = hway_s;
          // Write-or-both counts as a write: merge CPU bytes into the hit way.
          if (mem_write) begin
            load_data_s  = way_onehot(hway_s);
            set_dirty_s  = way_onehot(hway_s);
            datain_sel_s = DATAIN_CPU;
          end else begin
            load_data_s = '0;
          end
        end else begin
          mem_resp_s = 1'b0;
        end
      end
      WRITEBACK: begin
        pmem_write_s    = 1'b1;
        pmem_addr_sel_s = PMEM_ADDR_VICTIM;
        way_sel_s       = lru;
      end
      ALLOCATE: begin
        pmem_read_s     = 1'b1;
        pmem_addr_sel_s = PMEM_ADDR_CPU;
        way_sel_s       = lru;
        datain_sel_s    = DATAIN_PMEM;
        if (pmem_resp) begin
          load_data_s = way_onehot(lru);
          load_tag_s  = way_onehot(lru);
          set_valid_s = way_onehot(lru);
          clr_dirty_s = way_onehot(lru);
        end else begin
          load_data_s = '0;
        end
      end
      default: mem_resp_s = 1'b0;
    endcase
  end

  assign mem_resp      = mem_resp_s;
  assign pmem_read     = pmem_read_s;
  assign pmem_write    = pmem_write_s;
  assign pmem_addr_sel = pmem_addr_sel_s;
  assign way_sel       = way_sel_s;
  assign datain_sel    = datain_sel_s;
  assign load_lru      = load_lru_s;
  assign lru_in        = lru_in_s;
  assign load_data0    = load_data_s[0];
  assign load_data1    = load_data_s[1];
  assign load_tag0     = load_tag_s[0];
  assign load_tag1     = load_tag_s[1];
  assign set_valid0    = set_valid_s[0];
  assign set_valid1    = set_valid_s[1];
  assign set_dirty0    = set_dirty_s[0];
  assign set_dirty1    = set_dirty_s[1];
  assign clr_dirty0    = clr_dirty_s[0];
  assign clr_dirty1    = clr_dirty_s[1];

endmodule

// File: tb/tb_cache_control.sv
// Bench: behavioural cache datapath + memory around cache_control, with a flat reference memory scoreboard.
module tb_cache_control;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mem_read = 1'b0, mem_write = 1'b0;
  logic mem_resp, hit0, hit1, dirty0, dirty1, lru, pmem_resp;
  logic pmem_read, pmem_write, pmem_addr_sel, way_sel, datain_sel;
  logic load_data0, load_data1, load_tag0, load_tag1, set_valid0, set_valid1;
  logic set_dirty0, set_dirty1, clr_dirty0, clr_dirty1, load_lru, lru_in;

  logic [4:0] cur_addr = 5'd0;
  logic [7:0] cpu_wdata = 8'd0;
  logic [1:0] idx;
  logic [2:0] ctag;
  logic [4:0] pmem_addr;
  logic [7:0] pmem_rdata;

  bit [2:0] tag_a   [4][2];
  bit       valid_a [4][2];
  bit       dirty_a [4][2];
  bit [7:0] data_a  [4][2];
  bit       lru_a   [4];
  bit [7:0] pmem_mem [32];
  bit       pinit;
  int       pcnt;
  int       pmem_lat = 4;
  logic [7:0] ref_mem [32];

  typedef struct {
    bit         wr;
    logic [4:0] addr;
    logic [7:0] data;
  } exp_t;
  exp_t sb_q[$];

  int checks = 0;
  int errors = 0;

  logic [1:0] ld_data, ld_tag, st_valid, st_dirty, cl_dirty;
  logic [17:0] all_out;

  localparam logic [4:0] ADDR_A = 5'd4;   // tag 1, set 0
  localparam logic [4:0] ADDR_B = 5'd8;   // tag 2, set 0
  localparam logic [4:0] ADDR_C = 5'd12;  // tag 3, set 0
  localparam logic [4:0] ADDR_D = 5'd21;  // tag 5, set 1
  localparam logic [4:0] ADDR_E = 5'd26;  // tag 6, set 2

  cache_control dut (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write), .mem_resp(mem_resp),
    .hit0(hit0), .hit1(hit1), .dirty0(dirty0), .dirty1(dirty1), .lru(lru), .pmem_resp(pmem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_addr_sel(pmem_addr_sel),
    .way_sel(way_sel), .datain_sel(datain_sel),
    .load_data0(load_data0), .load_data1(load_data1), .load_tag0(load_tag0), .load_tag1(load_tag1),
    .set_valid0(set_valid0), .set_valid1(set_valid1), .set_dirty0(set_dirty0), .set_dirty1(set_dirty1),
    .clr_dirty0(clr_dirty0), .clr_dirty1(clr_dirty1), .load_lru(load_lru), .lru_in(lru_in)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_val(input int i);
    return 8'(i * 37 + 5);
  endfunction

  assign idx        = cur_addr[1:0];
  assign ctag       = cur_addr[4:2];
  assign hit0       = valid_a[idx][0] && (tag_a[idx][0] == ctag);
  assign hit1       = valid_a[idx][1] && (tag_a[idx][1] == ctag);
  assign dirty0     = dirty_a[idx][0];
  assign dirty1     = dirty_a[idx][1];
  assign lru        = lru_a[idx];
  assign pmem_addr  = pmem_addr_sel ? {tag_a[idx][way_sel], idx} : cur_addr;
  assign pmem_rdata = pmem_mem[pmem_addr];
  assign ld_data    = {load_data1, load_data0};
  assign ld_tag     = {load_tag1, load_tag0};
  assign st_valid   = {set_valid1, set_valid0};
  assign st_dirty   = {set_dirty1, set_dirty0};
  assign cl_dirty   = {clr_dirty1, clr_dirty0};
  assign all_out    = {mem_resp, pmem_read, pmem_write, pmem_addr_sel, way_sel, datain_sel,
                       load_data1, load_data0, load_tag1, load_tag0, set_valid1, set_valid0,
                       set_dirty1, set_dirty0, clr_dirty1, clr_dirty0, load_lru, lru_in};

  // Cache arrays: follow whatever enables the controller drives.
  always @(posedge clk) begin
    if (ld_data[0]) data_a[idx][0] <= datain_sel ? pmem_rdata : cpu_wdata;
    if (ld_data[1]) data_a[idx][1] <= datain_sel ? pmem_rdata : cpu_wdata;
    if (ld_tag[0]) tag_a[idx][0] <= ctag;
    if (ld_tag[1]) tag_a[idx][1] <= ctag;
    if (st_valid[0]) valid_a[idx][0] <= 1'b1;
    if (st_valid[1]) valid_a[idx][1] <= 1'b1;
    if (st_dirty[0]) dirty_a[idx][0] <= 1'b1;
    else if (cl_dirty[0]) dirty_a[idx][0] <= 1'b0;
    if (st_dirty[1]) dirty_a[idx][1] <= 1'b1;
    else if (cl_dirty[1]) dirty_a[idx][1] <= 1'b0;
    if (load_lru) lru_a[idx] <= lru_in;
  end

  // Physical memory: responds on the pmem_lat-th cycle of a request; reset discards in-flight work.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pmem_resp <= 1'b0;
      pcnt      <= 0;
      if (!pinit) begin
        for (int i = 0; i < 32; i++) pmem_mem[5'(i)] <= init_val(i);
        pinit <= 1'b1;
      end
    end else if (pmem_resp) begin
      pmem_resp <= 1'b0;
      pcnt      <= 0;
      if (pmem_write) pmem_mem[pmem_addr] <= data_a[idx][way_sel];
    end else if (pmem_read || pmem_write) begin
      if (pcnt + 1 >= pmem_lat - 1) pmem_resp <= 1'b1;
      else pcnt <= pcnt + 1;
    end
  end

  // Scoreboard monitor.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (pmem_read || pmem_write) begin
          checks++;
          if (pmem_read && pmem_write) begin
            errors++;
            $display("FAIL pmem_overlap: pmem_read=%0b pmem_write=%0b, required never both", pmem_read, pmem_write);
          end
        end
        if (mem_resp) begin
          checks++;
          if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL spurious_resp: mem_resp=1 with no pending request (addr %0d)", cur_addr);
          end else begin
            e = sb_q.pop_front();
            if (cur_addr !== e.addr) begin
              errors++;
              $display("FAIL resp_addr: completed addr %0d, required %0d", cur_addr, e.addr);
            end else if (e.wr) begin
              if (!ld_data[way_sel] || datain_sel) begin
                errors++;
                $display("FAIL wr_merge: load_data=%b datain_sel=%0b way_sel=%0b, required load on way_sel with datain_sel=0",
                         ld_data, datain_sel, way_sel);
              end
            end else if (data_a[idx][way_sel] !== e.data || ld_data !== 2'b00) begin
              errors++;
              $display("FAIL rd_data: addr %0d got 0x%0h (load_data=%b), required 0x%0h (load_data=00)",
                       e.addr, data_a[idx][way_sel], ld_data, e.data);
            end
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic issue(input bit wr, input logic [4:0] a, input logic [7:0] d, input bit expect_resp);
    exp_t e;
    cur_addr  = a;
    cpu_wdata = d;
    mem_write = wr;
    mem_read  = wr ? 1'($urandom_range(0, 1)) : 1'b1;
    if (expect_resp) begin
      e.wr   = wr;
      e.addr = a;
      e.data = ref_mem[a];
      if (wr) ref_mem[a] = d;
      sb_q.push_back(e);
    end
  endtask

  task automatic release_req();
    @(posedge clk);
    #1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  task automatic do_req(input bit wr, input logic [4:0] a, input logic [7:0] d);
    int n;
    n = 0;
    issue(wr, a, d, 1'b1);
    @(negedge clk);
    while (!mem_resp && n < 64) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!mem_resp) begin
      errors++;
      $display("FAIL resp_timeout: no mem_resp for addr %0d within 64 cycles", a);
      sb_q.delete();
    end
    release_req();
  endtask

  initial begin
    int n, wb, al, resp_seen;
    bit seen_read;
    for (int i = 0; i < 32; i++) ref_mem[5'(i)] = init_val(i);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", 32'(all_out), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Clean read miss into way 0, response on the 4th pmem cycle.
    @(posedge clk);
    #1 issue(1'b0, ADDR_A, 8'd0, 1'b1);
    @(negedge clk);
    chk("miss_c0", 32'({mem_resp, pmem_read, pmem_write}), 32'd0);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk("clean_pmem", 32'({pmem_read, pmem_write, pmem_addr_sel}), 32'(3'b100));
      if (c == 4) chk("clean_fill", 32'({load_data0, load_tag0, set_valid0, clr_dirty0, mem_resp}), 32'(5'b11110));
    end
    @(negedge clk);
    chk("clean_resp", 32'({mem_resp, pmem_read}), 32'(2'b10));
    release_req();

    do_req(1'b0, ADDR_B, 8'd0);
    do_req(1'b0, ADDR_A, 8'd0);

    // Read hit in way 1 while lru points at way 1.
    issue(1'b0, ADDR_B, 8'd0, 1'b1);
    @(negedge clk);
    chk("rd_hit_w1", 32'({mem_resp, load_lru, lru_in, way_sel, load_data1, load_data0}), 32'(6'b110100));
    release_req();

    // Write hit in way 0.
    issue(1'b1, ADDR_A, 8'hA5, 1'b1);
    @(negedge clk);
    chk("wr_hit_w0", 32'({mem_resp, load_data0, set_dirty0, datain_sel, way_sel, lru_in, load_data1}), 32'(7'b1110010));
    release_req();

    do_req(1'b1, ADDR_B, 8'h3C);
    do_req(1'b1, ADDR_A, 8'h77);

    // Dirty write miss: victim way 1 goes back to memory before the fill.
    issue(1'b1, ADDR_C, 8'h5A, 1'b1);
    wb = 0; al = 0; seen_read = 1'b0; n = 0;
    @(negedge clk);
    while (!mem_resp && n < 64) begin
      if (pmem_write) begin
        wb++;
        chk("wb_phase", 32'({pmem_read, pmem_addr_sel, seen_read}), 32'(3'b010));
      end
      if (pmem_read) begin
        al++;
        seen_read = 1'b1;
        chk("al_phase", 32'({pmem_write, pmem_addr_sel}), 32'd0);
      end
      @(negedge clk);
      n++;
    end
    chk("dirty_final", 32'({mem_resp, load_data1, datain_sel, set_dirty1}), 32'(4'b1101));
    chk("wb_cycles", 32'(wb), 32'd4);
    chk("al_cycles", 32'(al), 32'd4);
    release_req();

    // Asynchronous reset in the middle of a fill.
    issue(1'b0, ADDR_D, 8'd0, 1'b0);
    repeat (3) @(negedge clk);
    chk("alloc_before_rst", 32'(pmem_read), 32'd1);
    #2;
    rst_n    = 1'b0;
    mem_read = 1'b0;
    #1 chk("rst_async", 32'(pmem_read), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_outs", 32'(all_out), 32'd0);

    // Request dropped during a fill: the fill completes silently.
    @(posedge clk);
    #1 issue(1'b0, ADDR_E, 8'd0, 1'b0);
    repeat (3) @(negedge clk);
    mem_read  = 1'b0;
    n         = 0;
    resp_seen = 0;
    while (pmem_read && n < 20) begin
      @(negedge clk);
      if (mem_resp) resp_seen++;
      n++;
    end
    chk("drop_pmem_done", 32'(pmem_read), 32'd0);
    chk("drop_no_resp", 32'(resp_seen), 32'd0);
    chk("drop_line_loaded", 32'({valid_a[2][0], tag_a[2][0]}), 32'({1'b1, 3'd6}));
    chk("drop_idle_outs", 32'(all_out), 32'd0);

    // Randomized traffic against the flat reference memory.
    @(posedge clk);
    #1;
    for (int i = 0; i < 400; i++) begin
      pmem_lat = int'($urandom_range(2, 5));
      do_req(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 8'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_control.md
# cache_control

Sequencing FSM for the 2-way set-associative write-back L1 cache. Decodes CPU read/write requests against per-way hit/dirty status from the cache datapath and drives array load enables, the way select and data-source select of the write-data merge logic, and LRU updates. On a miss it runs the physical-memory handshake: victim write-back if dirty, then line allocate. Sits between the CPU-side memory port and the cache datapath / physical-memory port.

## Interface
- (no parameters): geometry is fixed in `cache_pkg`.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `mem_read` in 1: CPU read request, held until `mem_resp`.
- `mem_write` in 1: CPU write request, held until `mem_resp`.
- `mem_resp` out 1: request complete, one-cycle pulse.
- `hit0`, `hit1` in 1: way tag match AND valid, indexed set.
- `dirty0`, `dirty1` in 1: dirty bit of each way, indexed set.
- `lru` in 1: replacement way for indexed set.
- `pmem_resp` in 1: physical memory transaction done, one-cycle pulse.
- `pmem_read`, `pmem_write` out 1: physical memory requests, level, held until `pmem_resp`.
- `pmem_addr_sel` out 1: 0 = CPU line address, 1 = victim {tag, index}.
- `way_sel` out 1: way driven to the merge mux (hit way, or `lru` on miss path).
- `datain_sel` out 1: 0 = CPU byte-merged line, 1 = full `pmem` line.
- `load_data0`, `load_data1` out 1: data array write enable.
- `load_tag0`, `load_tag1`, `set_valid0`, `set_valid1` out 1.
- `set_dirty0`, `set_dirty1`, `clr_dirty0`, `clr_dirty1` out 1.
- `load_lru` out 1, `lru_in` out 1: LRU write enable and new value.

## Operation
- States: `IDLE`, `WRITEBACK`, `ALLOCATE`. Reset state `IDLE`.
- All outputs are Moore/Mealy combinational from state and inputs. All outputs are 0 in reset and whenever no condition below applies.
- `req = mem_read | mem_write`. Both high is treated as a write.
- `hit = hit0 | hit1`. `hway = hit1 & ~hit0`: both high is illegal, and way 0 wins.
- `IDLE`, `req & hit`:
  - `mem_resp=1`, `load_lru=1`, `lru_in=~hway`, `way_sel=hway`.
  - If write, also `load_data[hway]=1`, `set_dirty[hway]=1`, `datain_sel=0`.
  - Stay in `IDLE`.
- `IDLE`, `req & ~hit`:
  - Go to `WRITEBACK` if `dirty[lru]`, else `ALLOCATE`.
- `WRITEBACK`:
  - `pmem_write=1`, `pmem_addr_sel=1`, `way_sel=lru`.
  - On `pmem_resp`, go to `ALLOCATE`.
- `ALLOCATE`:
  - `pmem_read=1`, `pmem_addr_sel=0`, `way_sel=lru`, `datain_sel=1`.
  - On `pmem_resp`, assert `load_data[lru]`, `load_tag[lru]`, `set_valid[lru]` and `clr_dirty[lru]`, then go to `IDLE`.
  - The request then hits in `IDLE` and writes merge in that hit cycle.
- A started pmem transaction always completes, even if the CPU drops its request. The FSM then returns to `IDLE` with no `mem_resp`.
- `pmem_resp` in `IDLE` is ignored.

## Timing
- Hit: `mem_resp` in the same cycle the request is presented, so 0 added cycles.
- Clean miss: `ALLOCATE` for N cycles until `pmem_resp`, then 1 `IDLE` hit cycle.
  - `mem_resp` comes 1 cycle after the `pmem_resp` edge, at minimum cycle 3 from request.
- Dirty miss: `WRITEBACK` until the first `pmem_resp`, then `ALLOCATE` until the second, then `IDLE` hit.
- `pmem_read` and `pmem_write` never assert together. They deassert in the cycle after `pmem_resp` is sampled.
- `lru` is sampled every cycle. The datapath must hold the index stable while a request is pending, so `lru` is stable across a miss.
- Asynchronous reset mid-miss: state is forced to `IDLE` and pmem requests drop immediately. The in-flight pmem response is discarded.
- Back-to-back hits: one completion per cycle with no bubble.

## Structure
- `cache_pkg`: `state_t` enum (`IDLE`, `WRITEBACK`, `ALLOCATE`), way-count constant, and `pmem_addr_sel` / `datain_sel` encodings.
- Single module:
  - one `always_ff` for the state register (async clear on `!rst_n`);
  - one `always_comb` for next-state;
  - one `always_comb` for outputs.
- No sub-module. Per-way enables come from a one-hot decode of the selected way.

## Test plan
- Read hit way 1 (`hit1=1`, `lru=1`): `mem_resp=1` in the same cycle, `load_lru=1`, `lru_in=0`, no `load_data`.
- Write hit way 0: same cycle `load_data0=1`, `set_dirty0=1`, `datain_sel=0`, `way_sel=0`, `lru_in=1`.
- Clean read miss (`lru=0`, `dirty0=0`), `pmem_resp` on cycle 4:
  - `pmem_read` is high on cycles 1–4 with `pmem_addr_sel=0`;
  - cycle 4 shows `load_data0`, `load_tag0`, `set_valid0`, `clr_dirty0`;
  - `mem_resp` on cycle 5 once the bench raises `hit0`.
- Dirty write miss (`lru=1`, `dirty1=1`):
  - `pmem_write` with `pmem_addr_sel=1` until the first `pmem_resp`;
  - then `pmem_read`, never overlapping;
  - the final hit cycle shows `load_data1` with `datain_sel=0`.
- `rst_n` low during `ALLOCATE`: `pmem_read=0` asynchronously, and after release the state is `IDLE` with all outputs 0.
- Request dropped during `ALLOCATE`: the FSM still waits for `pmem_resp`, loads the line, returns to `IDLE`, and `mem_resp` is never asserted.
